// File: rtl/memarb_if.sv
// memarb_if -- bundle of the three buses that meet at the memory arbiter:
// the instruction requester, the data requester and the ramctrl memory port.
// slave  : the arbiter's view (takes requests, drives the memory port).
// master : the environment's view (requesters plus the memory).
interface memarb_if;

   // Instruction requester (read-only).
   logic        inst_stb;
   logic [21:0] inst_addr;
   logic [31:0] inst_dout;
   logic        inst_ack;

   // Data requester (load/store).
   logic        data_stb;
   logic        data_we;
   logic [21:0] data_addr;
   logic [31:0] data_din;
   logic [31:0] data_dout;
   logic        data_ack;

   // Shared memory port towards ramctrl.
   logic        mem_stb;
   logic        mem_we;
   logic [21:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mem_ack;

   modport slave (
      input  inst_stb, inst_addr,
      input  data_stb, data_we, data_addr, data_din,
      input  mem_dout, mem_ack,
      output inst_dout, inst_ack,
      output data_dout, data_ack,
      output mem_stb, mem_we, mem_addr, mem_din
   );

   modport master (
      output inst_stb, inst_addr,
      output data_stb, data_we, data_addr, data_din,
      output mem_dout, mem_ack,
      input  inst_dout, inst_ack,
      input  data_dout, data_ack,
      input  mem_stb, mem_we, mem_addr, mem_din
   );

endinterface

// File: rtl/memarb.sv
// memarb -- two-port memory arbiter in front of ramctrl.
// Shares one memory port between the instruction (icache refill) requester
// and the data (CPU load/store) requester. One transfer at a time; the winner's
// address / write-enable / write data are registered onto the memory port and
// the memory acknowledge and read data are routed back to the granted side only.
// Every transfer is followed by one mandatory IDLE cycle, so a strobe that is
// still high on the edge after its ack is never granted twice.
//
// Build option: define MEMARB_ROUNDROBIN_EN to alternate grants between the
// ports on a tie (the port not served last wins). Without it the data port has
// fixed priority on every tie.
module memarb (
   input  logic    clk,
   input  logic    rst,     // asynchronous, active low
   memarb_if.slave bus
);

   // FSM encoding.
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_I = 2'd1;
   localparam logic [1:0] GRANT_D = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_nxt;

   // Arbitration decision taken in IDLE.
   logic        any_req;
   logic        pick_d;

   // Registered memory-port request fields.
   logic        mem_we_q;
   logic [21:0] mem_addr_q;
   logic [31:0] mem_din_q;

`ifdef MEMARB_ROUNDROBIN_EN
   // Last-grant pointer: 1 = data port was served last.
   logic        last_d;
`endif

   assign any_req = bus.inst_stb | bus.data_stb;

   // Choose the winner among the strobes currently raised.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
      pick_d = 1'b0;
      if (bus.inst_stb && bus.data_stb) begin
`ifdef MEMARB_ROUNDROBIN_EN
         pick_d = ~last_d;
`else
         pick_d = 1'b1;
`endif
      end else begin
         pick_d = bus.data_stb;
      end
   end

   // Next-state logic: IDLE -> GRANT_x on a request, GRANT_x -> IDLE on ack.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = pick_d ? GRANT_D : GRANT_I;
            end
         end
         GRANT_I, GRANT_D: begin
            if (bus.mem_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset returns to IDLE at once, which also drops mem_stb.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Memory-port request fields, loaded only when a grant is issued from IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else if (state == IDLE && any_req) begin
         if (pick_d) begin
            mem_we_q   <= bus.data_we;
            mem_addr_q <= bus.data_addr;
            mem_din_q  <= bus.data_din;
         end else begin
            // Instruction fetch: read only, write data left as it was.
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.inst_addr;
         end
      end
   end

`ifdef MEMARB_ROUNDROBIN_EN
   // Remember which port completed the most recent transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_d <= 1'b1;
      end else if ((state == GRANT_I || state == GRANT_D) && bus.mem_ack) begin
         last_d <= (state == GRANT_D);
      end
   end
`endif

   // Memory port: strobe follows the grant state, fields come from registers.
   assign bus.mem_stb  = (state == GRANT_I) || (state == GRANT_D);
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;

   // Acks are routed combinationally to the granted port only.
   assign bus.inst_ack = bus.mem_ack && (state == GRANT_I);
   assign bus.data_ack = bus.mem_ack && (state == GRANT_D);

   // Read data is a plain pass-through; the ack qualifies it.
   assign bus.inst_dout = bus.mem_dout;
   assign bus.data_dout = bus.mem_dout;

endmodule

// File: tb/tb_memarb.sv
// tb_memarb -- directed, self-checking bench for memarb.
// Expected memory transactions are pushed to a scoreboard when a request is
// driven and popped when the memory port shows the next grant. The memory
// model responds with a programmable number of wait cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_memarb;

   logic clk = 1'b0;
   logic rst;

   memarb_if bus ();

   memarb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_d;
      logic        we;
      logic [21:0] addr;
      logic [31:0] din;
   } xact_t;

   xact_t       sb[$];
   xact_t       pend_i[$];
   xact_t       pend_d[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_din = '0;   // what mem_din should currently hold

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input xact_t t);
      if (t.is_d) begin
         bus.data_stb  = 1'b1;
         bus.data_we   = t.we;
         bus.data_addr = t.addr;
         bus.data_din  = t.din;
      end else begin
         bus.inst_stb  = 1'b1;
         bus.inst_addr = t.addr;
      end
   endtask

   function automatic xact_t mk(input logic is_d, input logic we,
                                input logic [21:0] addr, input logic [31:0] din);
      xact_t t;
      t.is_d = is_d;
      t.we   = we;
      t.addr = addr;
      t.din  = din;
      return t;
   endfunction

   // Requester reaction to its ack: issue the next queued request or drop.
   task automatic advance(input logic is_d, input bit drop);
      if (is_d) begin
         if (pend_d.size() != 0) drive(pend_d.pop_front());
         else if (drop) bus.data_stb = 1'b0;
      end else begin
         if (pend_i.size() != 0) drive(pend_i.pop_front());
         else if (drop) bus.inst_stb = 1'b0;
      end
   endtask

   // Memory model: wait for the grant, check the request against the
   // scoreboard while holding it for 'waits' cycles, then ack one cycle.
   task automatic serve(input int waits, input logic [31:0] rdata, input bit drop,
                        output int lat);
      xact_t       e;
      logic [31:0] exp_din;
      lat = 0;
      while (bus.mem_stb !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      if (bus.mem_stb !== 1'b1) begin
         check("grant_timeout", bus.mem_stb, 1);
         return;
      end
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      exp_din = e.is_d ? e.din : model_din;
      for (int k = 0; k <= waits; k++) begin
         check("mem_stb_hold", bus.mem_stb, 1);
         check("mem_we", bus.mem_we, e.we);
         check("mem_addr", bus.mem_addr, e.addr);
         check("mem_din", bus.mem_din, exp_din);
         check("no_early_ack", {bus.inst_ack, bus.data_ack}, 2'b00);
         if (k < waits) tick();
      end
      model_din     = exp_din;
      bus.mem_dout  = rdata;
      bus.mem_ack   = 1'b1;
      #1;
      check("inst_ack", bus.inst_ack, !e.is_d);
      check("data_ack", bus.data_ack, e.is_d);
      check("ack_dout", e.is_d ? bus.data_dout : bus.inst_dout, rdata);
      advance(e.is_d, drop);
      tick();
      bus.mem_ack  = 1'b0;
      bus.mem_dout = '0;
      #1;
      check("idle_after_ack", bus.mem_stb, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      xact_t t;
      int    lat;
      int    ii, di;
      logic  last_d, pick;
      xact_t ix[4];
      xact_t dx[4];

      rst           = 1'b0;
      bus.inst_stb  = 1'b0;
      bus.inst_addr = '0;
      bus.data_stb  = 1'b0;
      bus.data_we   = 1'b0;
      bus.data_addr = '0;
      bus.data_din  = '0;
      bus.mem_dout  = '0;
      bus.mem_ack   = 1'b1;   // stray ack while in reset must not be forwarded

      // ---- reset state ----
      tick();
      #1;
      check("rst_mem_stb", bus.mem_stb, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_din", bus.mem_din, 0);
      check("rst_acks", {bus.inst_ack, bus.data_ack}, 2'b00);
      tick();
      bus.mem_ack = 1'b0;
      rst = 1'b1;

      // ---- single instruction read, 2 wait cycles ----
      t = mk(1'b0, 1'b0, 22'h000100, 32'h0);
      drive(t);
      sb.push_back(t);
      serve(2, 32'hDEADBEEF, 1'b1, lat);
      check("t1_latency", lat, 1);
      tick();
      check("t1_no_dup_grant", bus.mem_stb, 0);

      // ---- data write, 1 wait cycle ----
      t = mk(1'b1, 1'b1, 22'h0003FF, 32'h12345678);
      drive(t);
      sb.push_back(t);
      serve(1, 32'h0, 1'b1, lat);
      check("t2_latency", lat, 1);

      // ---- zero-wait data read, then inst read keeps mem_din ----
      t = mk(1'b1, 1'b0, 22'h00002A, 32'hA5A5A5A5);
      drive(t);
      sb.push_back(t);
      serve(0, 32'hCAFEF00D, 1'b1, lat);
      t = mk(1'b0, 1'b0, 22'h3FFFFF, 32'h0);
      drive(t);
      sb.push_back(t);
      serve(0, 32'h0BADF00D, 1'b1, lat);

      // ---- inst request during data transfer: latched only at IDLE ----
      t = mk(1'b1, 1'b1, 22'h000155, 32'h0F0F0F0F);
      drive(t);
      sb.push_back(t);
      tick();
      bus.inst_stb  = 1'b1;
      bus.inst_addr = 22'h3A0000;
      tick();
      check("t3_busy_addr", bus.mem_addr, 22'h000155);
      check("t3_busy_we", bus.mem_we, 1);
      bus.inst_addr = 22'h000222;
      sb.push_back(mk(1'b0, 1'b0, 22'h000222, 32'h0));
      serve(2, 32'h0, 1'b1, lat);
      serve(1, 32'h11223344, 1'b1, lat);
      check("t3_inst_after_idle", lat, 1);

      // ---- stb held through the IDLE cycle: exactly one more transfer ----
      t = mk(1'b0, 1'b0, 22'h0ABCDE, 32'h0);
      drive(t);
      sb.push_back(t);
      sb.push_back(t);
      serve(0, 32'h55AA55AA, 1'b0, lat);
      serve(0, 32'hAA55AA55, 1'b1, lat);
      check("t4_regrant_latency", lat, 1);
      tick();
      check("t4_no_third_grant", bus.mem_stb, 0);
      tick();
      check("t4_still_idle", bus.mem_stb, 0);

      // ---- reset during GRANT_D before mem_ack ----
      drive(mk(1'b1, 1'b1, 22'h3FFFFF, 32'hFFFFFFFF));
      tick();
      check("t5_granted", bus.mem_stb, 1);
      check("t5_addr", bus.mem_addr, 22'h3FFFFF);
      #2;
      rst = 1'b0;
      #1;
      check("t5_rst_stb", bus.mem_stb, 0);
      check("t5_rst_we", bus.mem_we, 0);
      check("t5_rst_addr", bus.mem_addr, 0);
      check("t5_rst_din", bus.mem_din, 0);
      bus.data_stb = 1'b0;
      bus.mem_ack  = 1'b1;
      #1;
      check("t5_late_ack_in_rst", {bus.inst_ack, bus.data_ack}, 2'b00);
      tick();
      rst = 1'b1;
      #1;
      check("t5_late_ack_after_rst", {bus.inst_ack, bus.data_ack}, 2'b00);
      tick();
      bus.mem_ack = 1'b0;
      model_din   = '0;
      #1;
      check("t5_idle", bus.mem_stb, 0);

      // ---- continuous contention, 4 transfers per port, fresh from reset ----
      for (int k = 0; k < 4; k++) begin
         ix[k] = mk(1'b0, 1'b0, 22'h010000 + 22'(k), 32'h0);
         dx[k] = mk(1'b1, 1'(k % 2), 22'h020000 + 22'(k), 32'hD0000000 + 32'(k));
      end
      ii = 0;
      di = 0;
      last_d = 1'b1;
      for (int s = 0; s < 8; s++) begin
`ifdef MEMARB_ROUNDROBIN_EN
         pick = (ii < 4 && di < 4) ? !last_d : (di < 4);
`else
         pick = (di < 4);
`endif
         if (pick) begin
            sb.push_back(dx[di]);
            di++;
         end else begin
            sb.push_back(ix[ii]);
            ii++;
         end
         last_d = pick;
      end
      for (int k = 1; k < 4; k++) begin
         pend_i.push_back(ix[k]);
         pend_d.push_back(dx[k]);
      end
      drive(ix[0]);
      drive(dx[0]);
      for (int s = 0; s < 8; s++) begin
         serve(s % 2, 32'hA0000000 + 32'(s), 1'b1, lat);
      end
      check("t6_sb_drained", sb.size(), 0);
      tick();
      check("t6_final_idle", bus.mem_stb, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
